dot_seq_ctrl: RTL and testbench



---
 rtl/dot_seq_ctrl.sv | 104 ++++++++++
 tb/tb_dot_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_seq_ctrl.sv
// Job sequencer for an external 8-lane int8 MAC: streams chunk beats in,
// tracks beat validity alongside the MAC pipeline, and accumulates one signed result per job.
module dot_seq_ctrl #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  output logic              o_busy,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [63:0]       i_a_vec,
  input  logic [63:0]       i_b_vec,
  output logic              o_mac_nrst,
  output logic [63:0]       o_mac_a,
  output logic [63:0]       o_mac_b,
  input  logic [18:0]       i_mac_res,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state, state_next;
  logic [LEN_W-1:0]         len, count;
  logic [MAC_LAT-1:0]       vpipe, vpipe_next;
  logic signed [ACC_W-1:0]  acc, mac_ext, sum;
  logic                     ovf, accept, acc_en, ovf_now;

  // Abort and reset both gate ready so no beat is ever half-accepted.
  assign o_in_ready = (state == RUN) && (count < len) && !i_abort && !i_rst;
  assign accept     = o_in_ready && i_in_valid;
  assign vpipe_next = (vpipe << 1) | MAC_LAT'(accept);

  assign mac_ext = ACC_W'($signed(i_mac_res));
  assign sum     = acc + mac_ext;
  assign ovf_now = (acc[ACC_W-1] == mac_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign acc_en  = vpipe[MAC_LAT-1] && ((state == RUN) || (state == DRAIN)) && !i_abort;

  assign o_mac_nrst = ~i_rst;
  assign o_mac_a    = accept ? i_a_vec : '0;
  assign o_mac_b    = accept ? i_b_vec : '0;
  assign o_result   = acc;
  assign o_ovf      = ovf;

  always_comb begin
    state_next  = state;
    o_busy      = 1'b1;
    o_res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = (i_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (i_abort) state_next = IDLE;
        else if (accept && (count == len - 1'b1)) state_next = DRAIN;
      end
      DRAIN: begin
        // Leave once the final valid stage is being accumulated on this edge.
        if (i_abort) state_next = IDLE;
        else if (vpipe_next == '0) state_next = DONE;
      end
      DONE: begin
        o_res_valid = 1'b1;
        if (i_abort || i_res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      len   <= '0;
      count <= '0;
      vpipe <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      vpipe <= i_abort ? '0 : vpipe_next;
      if (state == IDLE && i_start) begin
        len   <= i_len;
        count <= '0;
        acc   <= '0;
        ovf   <= 1'b0;
      end else begin
        if (accept) count <= count + 1'b1;
        if (acc_en) begin
          acc <= sum;
          if (ovf_now) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Randomized scoreboard bench for dot_seq_ctrl with a behavioural MAC and
// a job-level reference model.
module tb_dot_seq_ctrl;

  localparam int LEN_W   = 8;
  localparam int ACC_W   = 24;
  localparam int MAC_LAT = 3;

  logic              i_clk, i_rst, i_start, i_abort, i_in_valid, i_res_ready;
  logic [LEN_W-1:0]  i_len;
  logic [63:0]       i_a_vec, i_b_vec, o_mac_a, o_mac_b;
  logic [18:0]       i_mac_res;
  logic              o_busy, o_in_ready, o_mac_nrst, o_res_valid, o_ovf;
  logic [ACC_W-1:0]  o_result;

  dot_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len), .i_abort(i_abort),
    .o_busy(o_busy), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a_vec(i_a_vec), .i_b_vec(i_b_vec), .o_mac_nrst(o_mac_nrst),
    .o_mac_a(o_mac_a), .o_mac_b(o_mac_b), .i_mac_res(i_mac_res),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_result(o_result), .o_ovf(o_ovf)
  );

  int checks = 0, failures = 0;
  int cyc = 0, n_done = 0, n_exp = 0, rise_cyc = 0, ready_cycles = 0;
  bit prev_v = 0;
  longint exp_res[$];
  bit     exp_ovf[$];
  logic [63:0] a_q[$], b_q[$];
  bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic int dot8(input logic [63:0] a, input logic [63:0] b);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
    return s;
  endfunction

  // Behavioural MAC: lane dot product visible MAC_LAT cycles after the inputs.
  logic [18:0] m0, m1, m2;
  always @(posedge i_clk) begin
    if (!o_mac_nrst) begin
      m0 <= '0; m1 <= '0; m2 <= '0;
    end else begin
      m0 <= 19'(dot8(o_mac_a, o_mac_b));
      m1 <= m0;
      m2 <= m1;
    end
  end
  assign i_mac_res = m2;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job-level reference: running two's-complement sum with sticky overflow.
  task automatic ref_model(input int len, output longint res, output bit ov);
    longint lim = longint'(1) << (ACC_W - 1);
    longint t;
    res = 0; ov = 0;
    for (int i = 0; i < len; i++) begin
      t = res + longint'(dot8(a_q[i], b_q[i]));
      if (t >= lim || t < -lim) ov = 1;
      if (t >= lim) t -= 2 * lim;
      if (t < -lim) t += 2 * lim;
      res = t;
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_in_ready) ready_cycles++;
      if (o_res_valid && !prev_v) rise_cyc = cyc;
      prev_v = o_res_valid;
      if (o_res_valid && i_res_ready) begin
        if (exp_res.size() == 0) check("unexpected_result", 1, 0);
        else begin
          check("result", longint'($signed(o_result)), exp_res.pop_front());
          check("ovf", longint'(o_ovf), longint'(exp_ovf.pop_front()));
        end
        n_done++;
      end
    end else prev_v = 0;
  end

  task automatic fill(input int n, input logic [63:0] a, input logic [63:0] b, input bit rnd);
    a_q.delete(); b_q.delete();
    for (int i = 0; i < n; i++) begin
      a_q.push_back(rnd ? {$urandom, $urandom} : a);
      b_q.push_back(rnd ? {$urandom, $urandom} : b);
    end
  endtask

  // vmode: 0 valid held high, 1 fixed gap pattern, 2 random valid.
  task automatic run_job(input int len, input int vmode, input int abort_after, output int s);
    int idx = 0, pi = 0, guard = 0, lim;
    bit acc_now;
    longint er; bit eo;
    ref_model(len, er, eo);
    if (abort_after == 0) begin
      exp_res.push_back(er); exp_ovf.push_back(eo); n_exp++;
    end
    lim = (abort_after != 0) ? abort_after : len;
    ready_cycles = 0;
    i_len = LEN_W'(len); i_start = 1; s = cyc;
    @(posedge i_clk); #1; i_start = 0;
    while (idx < lim && guard < 2000) begin
      case (vmode)
        0: i_in_valid = 1;
        1: i_in_valid = pat[pi % 7];
        default: i_in_valid = ($urandom % 4) != 0;
      endcase
      pi++;
      i_a_vec = a_q[idx]; i_b_vec = b_q[idx];
      @(negedge i_clk); acc_now = i_in_valid && o_in_ready;
      @(posedge i_clk); #1;
      if (acc_now) idx++;
      guard++;
    end
    if (guard >= 2000) check("beat_timeout", idx, lim);
    if (abort_after != 0) begin
      i_in_valid = 1; i_a_vec = a_q[idx]; i_b_vec = b_q[idx]; i_abort = 1;
      @(posedge i_clk); #1; i_abort = 0;
    end
    i_in_valid = 0; i_a_vec = '0; i_b_vec = '0;
  endtask

  task automatic wait_result();
    int g = 0;
    while (n_done < n_exp && g < 500) begin @(negedge i_clk); g++; end
    check("result_timeout", n_done, n_exp);
    @(posedge i_clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_in_ready"}, o_in_ready, 0);
    check({tag, "_res_valid"}, o_res_valid, 0);
    check({tag, "_ovf"}, o_ovf, 0);
    check({tag, "_result"}, longint'(o_result), 0);
    check({tag, "_mac_a"}, longint'(o_mac_a), 0);
  endtask

  initial begin
    int s;
    longint hold_r;
    i_rst = 1; i_start = 0; i_abort = 0; i_in_valid = 0; i_res_ready = 1;
    i_len = '0; i_a_vec = '0; i_b_vec = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    check("reset_mac_nrst", o_mac_nrst, 0);
    @(posedge i_clk); #1; i_rst = 0;
    @(negedge i_clk);
    check("mac_nrst_released", o_mac_nrst, 1);
    @(posedge i_clk); #1;

    // len=1, lane k a=k+1, b=2
    a_q.delete(); b_q.delete();
    a_q.push_back(64'h0807060504030201); b_q.push_back({8{8'd2}});
    run_job(1, 0, 0, s);
    wait_result();
    check("len1_latency", rise_cyc - s, 5);
    check("len1_ready_cycles", ready_cycles, 1);

    // gapped valid, a=-128, b=127
    fill(4, {8{8'h80}}, {8{8'h7f}}, 0);
    run_job(4, 1, 0, s);
    wait_result();
    check("gapped_ready_cycles", ready_cycles, 7);

    // overflow boundary
    fill(63, {8{8'h80}}, {8{8'h80}}, 0);
    run_job(63, 0, 0, s);
    wait_result();
    fill(64, {8{8'h80}}, {8{8'h80}}, 0);
    run_job(64, 0, 0, s);
    wait_result();

    // result held in DONE, start ignored
    i_res_ready = 0;
    fill(2, '0, '0, 1);
    run_job(2, 2, 0, s);
    for (int g = 0; g < 200 && !o_res_valid; g++) @(negedge i_clk);
    check("hold_valid_seen", o_res_valid, 1);
    hold_r = longint'(o_result);
    @(posedge i_clk); #1;
    for (int k = 0; k < 10; k++) begin
      i_start = (k % 2) == 0; i_len = 8'd3;
      @(negedge i_clk);
      check("hold_valid", o_res_valid, 1);
      check("hold_result", longint'(o_result), hold_r);
      @(posedge i_clk); #1;
    end
    i_start = 0; i_res_ready = 1;
    wait_result();
    @(negedge i_clk);
    check("hold_idle_after", o_busy, 0);
    @(posedge i_clk); #1;

    // abort after 3rd beat, then a clean len=1 job
    fill(8, '0, '0, 1);
    run_job(8, 0, 3, s);
    check("abort_idle", o_busy, 0);
    fill(1, {8{8'h01}}, {8{8'h01}}, 0);
    run_job(1, 0, 0, s);
    wait_result();

    // len=0
    run_job(0, 0, 0, s);
    wait_result();
    check("len0_latency", rise_cyc - s, 1);

    // reset mid-RUN
    fill(5, '0, '0, 1);
    i_len = 8'd5; i_start = 1;
    @(posedge i_clk); #1; i_start = 0; i_in_valid = 1; i_a_vec = a_q[0]; i_b_vec = b_q[0];
    repeat (2) @(posedge i_clk);
    #1; i_rst = 1;
    @(negedge i_clk);
    check("midrst_mac_nrst", o_mac_nrst, 0);
    check("midrst_mac_b", longint'(o_mac_b), 0);
    @(posedge i_clk); #1; i_rst = 0; i_in_valid = 0;
    @(negedge i_clk);
    check_reset_outputs("midrst");
    @(posedge i_clk); #1;

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int l = $urandom_range(1, 12);
      fill(l, '0, '0, 1);
      run_job(l, 2, 0, s);
      wait_result();
    end

    check("queue_empty", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
